diram_channel_model: RTL and testbench

- Synthesizable single-channel DiRAM responder, one instance per manager.
- Sits directly downstream of each manager's DFI command/write port and closes the loop back into phy__dfi__valid/phy__dfi__data.
- Decodes cs/cmd1/cmd0 commands, tracks open rows per bank, stores write data and returns read data after a fixed latency.
- Used for system-level simulation and emulation in place of the physical DiRAM stack.

---
 rtl/diram_channel_model_pkg.sv | 36 +++
 rtl/diram_rd_lat_pipe.sv | 55 +++++
 rtl/diram_channel_model.sv | 181 ++++++++++++++++++
 tb/tb_diram_channel_model.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diram_channel_model_pkg.sv
// Shared manager DRAM definitions: DiRAM sizing defaults, command encodings,
// per-bank state encoding and the poison word returned for illegal reads.
package diram_channel_model_pkg;

    // Manager-level DRAM ranges
    localparam int MGR_DRAM_BANKS  = 4;
    localparam int MGR_DRAM_DATA_W = 64;

    // Bank-select width for a given bank count (at least one bit)
    function automatic int bank_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // DiRAM geometry defaults
    localparam int DIRAM_BANK_W = bank_bits(MGR_DRAM_BANKS);
    localparam int DIRAM_ROW_W  = 4;
    localparam int DIRAM_COL_W  = 4;

    // Data returned for a READ that targets a closed bank
    localparam logic [63:0] DIRAM_POISON = 64'hDEAD_BEEF_DEAD_BEEF;

    // {cmd1, cmd0} command encodings
    typedef enum logic [1:0] {
        DIRAM_CMD_PRECHARGE = 2'b00,
        DIRAM_CMD_READ      = 2'b01,
        DIRAM_CMD_WRITE     = 2'b10,
        DIRAM_CMD_ACTIVATE  = 2'b11
    } diram_cmd_e;

    // Per-bank row state
    typedef enum logic {
        BANK_CLOSED = 1'b0,
        BANK_OPEN   = 1'b1
    } bank_state_e;

endpackage

// File: rtl/diram_rd_lat_pipe.sv
// Read-return pipe: DEPTH-stage valid+data shift register. Each data stage
// only loads when a valid word enters it, so the output data holds its last
// returned value while valid is low.
module diram_rd_lat_pipe
    import diram_channel_model_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = MGR_DRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              in_vld_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_vld_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] data_q [DEPTH];

    // Input seen by each stage: the pipe input for stage 0, else the previous stage
    logic [DEPTH-1:0]  vld_d;
    logic [DATA_W-1:0] data_d [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign vld_d[gi]  = in_vld_i;
            assign data_d[gi] = in_data_i;
        end else begin : g_next
            assign vld_d[gi]  = vld_q[gi-1];
            assign data_d[gi] = data_q[gi-1];
        end
    end

    // Shift valids every cycle; advance data only alongside a valid
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (vld_d[i]) begin
                    data_q[i] <= data_d[i];
                end
            end
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_data_o = data_q[DEPTH-1];

endmodule

// File: rtl/diram_channel_model.sv
// Single-channel DiRAM responder: decodes DFI commands, tracks the open row
// of every bank, stores write data and returns read data after RD_LAT cycles.
module diram_channel_model
    import diram_channel_model_pkg::*;
#(
    parameter int          BANKS      = MGR_DRAM_BANKS,
    parameter int          ADDR_W     = 12,
    parameter int          ROW_W      = DIRAM_ROW_W,
    parameter int          COL_W      = DIRAM_COL_W,
    parameter int          DATA_W     = MGR_DRAM_DATA_W,
    parameter int          CLK_GROUPS = 2,
    parameter int          RD_LAT     = 4,
    parameter logic [63:0] POISON     = DIRAM_POISON,
    localparam int         BANK_W     = bank_bits(BANKS)
) (
    input  logic                  clk,
    input  logic                  reset_poweron,
    input  logic                  dfi__phy__cs,
    input  logic                  dfi__phy__cmd1,
    input  logic                  dfi__phy__cmd0,
    input  logic [BANK_W-1:0]     dfi__phy__bank,
    input  logic [ADDR_W-1:0]     dfi__phy__addr,
    input  logic [DATA_W-1:0]     dfi__phy__data,
    output logic [CLK_GROUPS-1:0] phy__dfi__valid,
    output logic [DATA_W-1:0]     phy__dfi__data,
    output logic [BANKS-1:0]      open_bank_mask,
    output logic [7:0]            prot_err_cnt
);

    localparam int IDX_W = BANK_W + ROW_W + COL_W;
    localparam int DEPTH = 1 << IDX_W;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    diram_cmd_e cmd;
    logic       is_act, is_pre, is_rd, is_wr;
    logic       tgt_open;

    assign cmd    = diram_cmd_e'({dfi__phy__cmd1, dfi__phy__cmd0});
    assign is_act = dfi__phy__cs && (cmd == DIRAM_CMD_ACTIVATE);
    assign is_pre = dfi__phy__cs && (cmd == DIRAM_CMD_PRECHARGE);
    assign is_rd  = dfi__phy__cs && (cmd == DIRAM_CMD_READ);
    assign is_wr  = dfi__phy__cs && (cmd == DIRAM_CMD_WRITE);

    // Only the low column/row bits of the address bus are meaningful
    logic unused_addr;
    assign unused_addr = ^dfi__phy__addr;

    // ------------------------------------------------------------------
    // Per-bank CLOSED/OPEN state and open row
    // ------------------------------------------------------------------
    logic [BANKS-1:0]            bank_open;
    logic [BANKS-1:0][ROW_W-1:0] bank_row;

    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
        bank_state_e      state_q, state_d;
        logic [ROW_W-1:0] row_q, row_d;
        logic             hit;

        assign hit = (dfi__phy__bank == BANK_W'(gi));

        // Next state: ACTIVATE opens (or re-targets) the row, PRECHARGE closes
        always_comb begin
            state_d = state_q;
            row_d   = row_q;
            if (hit && is_act) begin
                state_d = BANK_OPEN;
                row_d   = dfi__phy__addr[ROW_W-1:0];
            end else if (hit && is_pre) begin
                state_d = BANK_CLOSED;
            end
        end

        // Bank state register
        always_ff @(posedge clk or posedge reset_poweron) begin
            if (reset_poweron) begin
                state_q <= BANK_CLOSED;
                row_q   <= '0;
            end else begin
                state_q <= state_d;
                row_q   <= row_d;
            end
        end

        assign bank_open[gi] = (state_q == BANK_OPEN);
        assign bank_row[gi]  = row_q;
    end

    assign open_bank_mask = bank_open;
    assign tgt_open       = bank_open[dfi__phy__bank];

    // ------------------------------------------------------------------
    // Storage: one word per {bank, row, column}; never cleared by reset
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  mem_idx;
    logic              wr_en, rd_en;
    logic [DATA_W-1:0] ram_rd_q;

    assign mem_idx = {dfi__phy__bank, bank_row[dfi__phy__bank], dfi__phy__addr[COL_W-1:0]};
    // Memory has no reset, so suppress its ports explicitly while reset is held
    assign wr_en   = is_wr && tgt_open && !reset_poweron;
    assign rd_en   = is_rd && tgt_open && !reset_poweron;

    // Write port: store data on the WRITE edge
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[mem_idx] <= dfi__phy__data;
        end
    end

    // Registered read port: a write on the previous edge is already visible
    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_rd_q <= mem[mem_idx];
        end
    end

    // ------------------------------------------------------------------
    // Read issue tracking and latency pipe
    // ------------------------------------------------------------------
    logic              rd_vld_q, rd_poison_q;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_vld;

    // Remember that a READ was taken this edge and whether it hit a closed bank
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            rd_vld_q    <= 1'b0;
            rd_poison_q <= 1'b0;
        end else begin
            rd_vld_q    <= is_rd;
            rd_poison_q <= is_rd && !tgt_open;
        end
    end

    assign rd_word = rd_poison_q ? DATA_W'(POISON) : ram_rd_q;

    diram_rd_lat_pipe #(
        .DEPTH  (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk        (clk),
        .rst_i      (reset_poweron),
        .in_vld_i   (rd_vld_q),
        .in_data_i  (rd_word),
        .out_vld_o  (pipe_vld),
        .out_data_o (phy__dfi__data)
    );

    assign phy__dfi__valid = {CLK_GROUPS{pipe_vld}};

    // ------------------------------------------------------------------
    // Protocol error counter (saturating)
    // ------------------------------------------------------------------
    logic       prot_err;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign prot_err = (is_act && tgt_open) || ((is_rd || is_wr) && !tgt_open);

    // Count offending commands, stopping at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (prot_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign prot_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_diram_channel_model.sv
// Self-checking bench for diram_channel_model: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_diram_channel_model;

    localparam int RD_LAT = 4;
    localparam logic [1:0] C_PRE = 2'b00;
    localparam logic [1:0] C_RD  = 2'b01;
    localparam logic [1:0] C_WR  = 2'b10;
    localparam logic [1:0] C_ACT = 2'b11;
    localparam logic [63:0] POISON_WORD = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset_poweron;
    logic        cs, cmd1, cmd0;
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [1:0]  valid;
    logic [63:0] rdata;
    logic [3:0]  mask;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    diram_channel_model dut (
        .clk             (clk),
        .reset_poweron   (reset_poweron),
        .dfi__phy__cs    (cs),
        .dfi__phy__cmd1  (cmd1),
        .dfi__phy__cmd0  (cmd0),
        .dfi__phy__bank  (bank),
        .dfi__phy__addr  (addr),
        .dfi__phy__data  (wdata),
        .phy__dfi__valid (valid),
        .phy__dfi__data  (rdata),
        .open_bank_mask  (mask),
        .prot_err_cnt    (err_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [63:0] data;
        bit          known;
    } rd_t;

    typedef struct {
        int          c;
        logic [63:0] d;
    } vlog_t;

    bit          m_open [4];
    int          m_row  [4];
    int          m_err = 0;
    logic [63:0] m_mem  [int];
    rd_t         m_rdq  [$];
    vlog_t       vlog   [$];

    // Model update on every clock edge and on an asynchronous reset edge
    initial begin
        int  b, col, key;
        rd_t r;
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 0;
            m_row[i]  = 0;
        end
        forever begin
            @(posedge clk or posedge reset_poweron);
            cyc++;
            if (reset_poweron) begin
                for (int i = 0; i < 4; i++) begin
                    m_open[i] = 0;
                    m_row[i]  = 0;
                end
                m_err = 0;
                m_rdq.delete();
            end else if (cs === 1'b1) begin
                b   = int'(bank);
                col = int'(addr[3:0]);
                key = b * 256 + m_row[b] * 16 + col;
                case ({cmd1, cmd0})
                    C_ACT: begin
                        if (m_open[b] && m_err < 255) m_err++;
                        m_open[b] = 1;
                        m_row[b]  = int'(addr[3:0]);
                    end
                    C_PRE: m_open[b] = 0;
                    C_WR: begin
                        if (m_open[b]) m_mem[key] = wdata;
                        else if (m_err < 255) m_err++;
                    end
                    default: begin
                        r.due = cyc + RD_LAT;
                        if (!m_open[b]) begin
                            r.data  = POISON_WORD;
                            r.known = 1;
                            if (m_err < 255) m_err++;
                        end else if (m_mem.exists(key)) begin
                            r.data  = m_mem[key];
                            r.known = 1;
                        end else begin
                            r.data  = '0;
                            r.known = 0;
                        end
                        m_rdq.push_back(r);
                    end
                endcase
            end
        end
    end

    // Compare DUT outputs against the model every cycle, away from the clock edge
    initial begin
        logic [63:0] hold = '0;
        bit          known = 1;
        bit          ev;
        logic [3:0]  mm;
        rd_t         r;
        forever begin
            @(negedge clk);
            if (valid[0] === 1'b1) begin
                vlog.push_back('{c: cyc, d: rdata});
            end
            if (chk_en) begin
                ev = 0;
                if (m_rdq.size() > 0 && m_rdq[0].due == cyc) begin
                    r  = m_rdq.pop_front();
                    ev = 1;
                    if (r.known) begin
                        hold  = r.data;
                        known = 1;
                    end else begin
                        known = 0;
                    end
                end
                if (reset_poweron) begin
                    hold  = '0;
                    known = 1;
                end
                for (int i = 0; i < 4; i++) mm[i] = m_open[i];
                chk("valid", 64'(valid), ev ? 64'h3 : 64'h0);
                if (known) chk("rdata", rdata, hold);
                chk("mask", 64'(mask), 64'(mm));
                chk("errcnt", 64'(err_cnt), 64'(m_err));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit en, input logic [1:0] c, input int b, input int a,
                         input logic [63:0] d, output int edge_no);
        @(negedge clk);
        cs          = en;
        {cmd1, cmd0} = c;
        bank        = 2'(b);
        addr        = 12'(a);
        wdata       = d;
        @(posedge clk);
        #1;
        edge_no = cyc;
        cs      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk) cs = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs            = 1'b0;
        reset_poweron = 1'b1;
        repeat (2) @(negedge clk);
        reset_poweron = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e, e0, r, a;
        logic [1:0] c;
        reset_poweron = 1'b1;
        cs = 1'b0; cmd1 = 1'b0; cmd0 = 1'b0; bank = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", 64'(valid), 64'h0);
        chk("reset_data", rdata, 64'h0);
        chk("reset_mask", 64'(mask), 64'h0);
        chk("reset_err", 64'(err_cnt), 64'h0);
        reset_poweron = 1'b0;
        chk_en = 1;

        // T1: activate, write, read back after RD_LAT
        issue(1, C_ACT, 0, 3, 0, e);
        issue(1, C_WR, 0, 5, 64'h1111, e);
        vlog.delete();
        issue(1, C_RD, 0, 5, 0, e);
        idle(8);
        chk("t1_nvalid", 64'(vlog.size()), 64'd1);
        if (vlog.size() >= 1) begin
            chk("t1_latency", 64'(vlog[0].c - e), 64'd4);
            chk("t1_data", vlog[0].d, 64'h1111);
        end
        chk("t1_mask", 64'(mask), 64'b0001);
        chk("t1_err", 64'(err_cnt), 64'd0);

        // T2: read and write to a closed bank
        vlog.delete();
        issue(1, C_RD, 2, 0, 0, e);
        idle(8);
        chk("t2_nvalid", 64'(vlog.size()), 64'd1);
        if (vlog.size() >= 1) chk("t2_poison", vlog[0].d, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t2_err_rd", 64'(err_cnt), 64'd1);
        issue(1, C_WR, 2, 1, 64'h5555, e);
        chk("t2_err_wr", 64'(err_cnt), 64'd2);

        // T3: eight back-to-back reads
        issue(1, C_ACT, 1, 2, 0, e);
        for (int i = 0; i < 8; i++) issue(1, C_WR, 1, i, 64'(i), e);
        vlog.delete();
        e0 = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1, C_RD, 1, i, 0, e);
            if (i == 0) e0 = e;
        end
        idle(8);
        chk("t3_nvalid", 64'(vlog.size()), 64'd8);
        for (int i = 0; i < vlog.size(); i++) begin
            chk("t3_data", vlog[i].d, 64'(i));
            chk("t3_cycle", 64'(vlog[i].c), 64'(e0 + 4 + i));
        end

        // T4: asynchronous reset with reads in flight
        do_reset();
        issue(1, C_ACT, 3, 0, 0, e);
        issue(1, C_WR, 3, 0, 64'hA0, e);
        issue(1, C_WR, 3, 1, 64'hA1, e);
        issue(1, C_RD, 3, 0, 0, e);
        issue(1, C_RD, 3, 1, 0, e);
        repeat (3) @(posedge clk);
        #2;
        chk("t4_valid_before", 64'(valid), 64'h3);
        chk("t4_data_before", rdata, 64'hA0);
        reset_poweron = 1'b1;
        #1;
        chk("t4_valid_drop", 64'(valid), 64'h0);
        chk("t4_mask", 64'(mask), 64'h0);
        chk("t4_err", 64'(err_cnt), 64'h0);
        repeat (3) @(negedge clk);
        vlog.delete();
        reset_poweron = 1'b0;
        idle(10);
        chk("t4_no_valid_after", 64'(vlog.size()), 64'd0);

        // T5: re-activate an open bank, row selection, precharge
        issue(1, C_ACT, 0, 1, 0, e);
        issue(1, C_WR, 0, 0, 64'h0101, e);
        issue(1, C_ACT, 0, 6, 0, e);
        chk("t5_err", 64'(err_cnt), 64'd1);
        issue(1, C_WR, 0, 0, 64'h0606, e);
        vlog.delete();
        issue(1, C_RD, 0, 0, 0, e);
        idle(8);
        if (vlog.size() >= 1) chk("t5_row6", vlog[0].d, 64'h0606);
        else chk("t5_row6_nvalid", 64'(vlog.size()), 64'd1);
        issue(1, C_PRE, 0, 0, 0, e);
        chk("t5_mask_pre", 64'(mask), 64'h0);
        issue(1, C_ACT, 0, 1, 0, e);
        vlog.delete();
        issue(1, C_RD, 0, 0, 0, e);
        idle(8);
        if (vlog.size() >= 1) chk("t5_row1", vlog[0].d, 64'h0101);
        else chk("t5_row1_nvalid", 64'(vlog.size()), 64'd1);
        chk("t5_err_end", 64'(err_cnt), 64'd1);

        // T6: error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue(1, C_RD, $urandom_range(0, 3), $urandom_range(0, 15), 0, e);
            if (i == 100) chk("t6_err_mid", 64'(err_cnt), 64'd101);
        end
        idle(8);
        chk("t6_err_sat", 64'(err_cnt), 64'hFF);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 255);
            if (r == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 7))
                    0:       c = C_PRE;
                    1, 2:    c = C_ACT;
                    3, 4:    c = C_WR;
                    default: c = C_RD;
                endcase
                a = int'($urandom & 32'hFF0) | int'($urandom_range(0, 3));
                issue($urandom_range(0, 3) != 0, c, $urandom_range(0, 3), a,
                      {$urandom, $urandom}, e);
            end
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
